rca_serial_seq: RTL and testbench
=================================

// Module: rca_serial_seq
// PURPOSE
//   Bit-serial add sequencer. Reuses one rca_fA full-adder cell over WIDTH clock
//   cycles, LSB first, in place of a WIDTH-bit ripple chain. Operands enter and
//   results leave through valid/ready handshakes. Sits beside the ripple-carry adder
//   as the low-area alternative for non-throughput-critical sums.
// PARAMETERS
//   WIDTH  8  operand/result width in bits (>=2); also cycles per operation
// PORTS
//   clk          in   1      rising-edge clock
//   rst_n        in   1      synchronous reset, active low
//   start_valid  in   1      operand request
//   start_ready  out  1      block can accept operands (high only in IDLE)
//   A            in   WIDTH  operand A, sampled on accept
//   B            in   WIDTH  operand B, sampled on accept
//   Cin          in   1      carry-in, sampled on accept
//   Sum          out  WIDTH  result, valid while done_valid
//   Cout         out  1      carry-out, valid while done_valid
//   done_valid   out  1      result available
//   done_ready   in   1      consumer takes result
//   busy         out  1      high in CALC or DONE
// BEHAVIOUR
//   Clocking: one clock, clk. Reset rst_n is synchronous, active low.
//   Reset: state=IDLE; Sum=0; Cout=0; done_valid=0; busy=0; start_ready=1.
//     Shift registers, carry FF and bit counter cleared.
//   FSM IDLE -> CALC -> DONE -> IDLE.
//   - IDLE: start_ready=1. Accept on start_valid&&start_ready.
//     On accept: load A->a_sh, B->b_sh, Cin->carry FF, counter=0, go CALC.
//   - CALC: each cycle the full adder sees a_sh[0], b_sh[0], carry.
//     Per cycle: a_sh/b_sh shift right; sum bit enters res_sh[WIDTH-1] (shift right);
//     carry FF takes the adder Cout; counter++. After the WIDTH-th bit -> DONE.
//   - DONE: done_valid=1. Sum=res_sh and Cout=carry, held stable.
//     On done_valid&&done_ready -> IDLE (start_ready=1 the next cycle).
//   Latency: done_valid rises exactly WIDTH cycles after the accepting edge.
//     Minimum accept-to-accept interval is WIDTH+2 cycles.
//   Sum/Cout hold the last result after the handshake until the next DONE.
//     Their value is defined only while done_valid=1.
//   start_valid in CALC/DONE is ignored; no operand sampled; requester must hold.
//   Simultaneous done handshake and start_valid: start is not accepted that cycle.
//   Counter is $clog2(WIDTH)+1 bits; no wrap inside an operation.
//   Arithmetic: {Cout,Sum} = A + B + Cin, modulo 2^(WIDTH+1).
//   Reset mid-operation aborts immediately; the partial result is discarded.
// CONFIGURATION
//   RCA_SUB_EN defined: adds input port sub (1 bit, sampled on accept).
//     sub=1: b_sh loads ~B, carry FF loads 1, Cin ignored.
//       Result is Sum=A-B; Cout=1 means no borrow.
//     sub=0: identical to the add path.
//   RCA_SUB_EN undefined: no sub port, add only; all other timing identical.
// TESTING  (WIDTH=8)
//   1. A=0x5A B=0x33 Cin=0, done_ready=1 -> Sum=0x8D Cout=0.
//      done_valid exactly 8 cycles after the accepting edge.
//   2. A=0xFF B=0x01 Cin=0 -> Sum=0x00 Cout=1.
//      A=0xFF B=0xFF Cin=1 -> Sum=0xFF Cout=1.
//   3. done_ready=0 for 5 cycles in DONE -> Sum/Cout/done_valid stable.
//      start_valid pulsed in CALC and DONE -> not accepted; start_ready=0 throughout.
//   4. Back-to-back: start_valid held high, done_ready=1 -> accepts 10 cycles apart.
//      Each result is correct.
//   5. rst_n=0 on the 4th CALC cycle -> next edge: all outputs at reset values.
//      Then start_ready=1, and a new op (0x01+0x01) returns 0x02.
//   6. RCA_SUB_EN: A=0x10 B=0x20 sub=1 -> Sum=0xF0 Cout=0.
//      A=0x20 B=0x10 sub=1 -> Sum=0x10 Cout=1.

Source files
------------

// File: rtl/rca_serial_seq_if.sv
// Operand/result handshake bundle for rca_serial_seq.
// The sub port exists only when RCA_SUB_EN is defined.
interface rca_serial_seq_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
`ifdef RCA_SUB_EN
  logic             sub;
`endif
  logic [WIDTH-1:0] Sum;
  logic             Cout;
  logic             done_valid;
  logic             done_ready;
  logic             busy;

`ifdef RCA_SUB_EN
  modport master (
    output start_valid, A, B, Cin, sub, done_ready,
    input  start_ready, Sum, Cout, done_valid, busy
  );
  modport slave (
    input  start_valid, A, B, Cin, sub, done_ready,
    output start_ready, Sum, Cout, done_valid, busy
  );
`else
  modport master (
    output start_valid, A, B, Cin, done_ready,
    input  start_ready, Sum, Cout, done_valid, busy
  );
  modport slave (
    input  start_valid, A, B, Cin, done_ready,
    output start_ready, Sum, Cout, done_valid, busy
  );
`endif
endinterface

// File: rtl/rca_serial_seq.sv
// Bit-serial adder: one full-adder cell reused over WIDTH cycles, LSB first.
// Define RCA_SUB_EN to add the sub input (A-B via ~B and carry-in of 1).
module rca_serial_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  rca_serial_seq_if.slave  bus
);
  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh, sum_q;
  logic             carry, cout_q;
  logic [CW-1:0]    cnt;
  logic             fa_s, fa_c;
  logic             accept, last_bit, done_hs;
  logic [WIDTH-1:0] b_load;
  logic             c_load;

  always_comb begin
    fa_s = a_sh[0] ^ b_sh[0] ^ carry;
    fa_c = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));
  end

  always_comb begin
    accept   = (state == IDLE) && bus.start_valid;
    last_bit = (state == CALC) && (cnt == CW'(WIDTH - 1));
    done_hs  = (state == DONE) && bus.done_ready;
`ifdef RCA_SUB_EN
    b_load   = bus.sub ? ~bus.B : bus.B;
    c_load   = bus.sub | bus.Cin;
`else
    b_load   = bus.B;
    c_load   = bus.Cin;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)   state_nxt = CALC;
      CALC:    if (last_bit) state_nxt = DONE;
      DONE:    if (done_hs)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Result is latched on the final bit so Sum/Cout hold across the next CALC.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      sum_q  <= '0;
      carry  <= 1'b0;
      cout_q <= 1'b0;
      cnt    <= '0;
    end else if (accept) begin
      a_sh  <= bus.A;
      b_sh  <= b_load;
      carry <= c_load;
      cnt   <= '0;
    end else if (state == CALC) begin
      a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
      b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
      res_sh <= {fa_s, res_sh[WIDTH-1:1]};
      carry  <= fa_c;
      cnt    <= cnt + CW'(1);
      if (last_bit) begin
        sum_q  <= {fa_s, res_sh[WIDTH-1:1]};
        cout_q <= fa_c;
      end
    end
  end

  always_comb begin
    bus.start_ready = (state == IDLE);
    bus.done_valid  = (state == DONE);
    bus.busy        = (state != IDLE);
    bus.Sum         = sum_q;
    bus.Cout        = cout_q;
  end
endmodule

// File: tb/tb_rca_serial_seq.sv
// Scoreboard bench for rca_serial_seq at WIDTH=8; expected {Cout,Sum} queued on accept.
module tb_rca_serial_seq;
  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  rca_serial_seq_if #(.WIDTH(W)) bus();
  rca_serial_seq #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passed = 0;
  logic [W:0] sb[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_accept(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic cin, input logic sub, output bit ok);
    int n;
    logic [W-1:0] nb;
    n = 0;
    nb = ~b;
    bus.A = a;
    bus.B = b;
    bus.Cin = cin;
`ifdef RCA_SUB_EN
    bus.sub = sub;
`endif
    bus.start_valid = 1'b1;
    while (!bus.start_ready && n < 30) begin
      tick();
      n++;
    end
    ok = bus.start_ready;
    if (ok) begin
      tick();
      if (sub) sb.push_back({1'b0, a} + {1'b0, nb} + (W+1)'(1));
      else     sb.push_back({1'b0, a} + {1'b0, b} + (W+1)'(cin));
    end
    bus.start_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!bus.done_valid && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++; if (bus.start_ready !== 1'b1) $display("FAIL reset_start_ready: got %b expected 1", bus.start_ready); else passed++;
    checks++; if (bus.done_valid !== 1'b0) $display("FAIL reset_done_valid: got %b expected 0", bus.done_valid); else passed++;
    checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", bus.busy); else passed++;
    checks++; if ({bus.Cout, bus.Sum} !== 9'h000) $display("FAIL reset_result: got %h expected 000", {bus.Cout, bus.Sum}); else passed++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_add();
    logic [W-1:0] av[6];
    logic [W-1:0] bv[6];
    logic         cv[6];
    logic [W:0]   exp;
    bit ok;
    int n;
    av = '{8'h5A, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00};
    bv = '{8'h33, 8'h01, 8'hFF, 8'h00, 8'h00, 8'h00};
    cv = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 3; i < 6; i++) begin
      av[i] = W'($urandom);
      bv[i] = W'($urandom);
      cv[i] = 1'($urandom);
    end
    bus.done_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      do_accept(av[i], bv[i], cv[i], 1'b0, ok);
      checks++; if (!ok) $display("FAIL add_accept[%0d]: got timeout expected accept", i); else passed++;
      wait_valid(n);
      checks++; if (n !== 8) $display("FAIL add_latency[%0d]: got %0d expected 8", i, n); else passed++;
      exp = (sb.size() != 0) ? sb.pop_front() : 'x;
      checks++; if ({bus.Cout, bus.Sum} !== exp) $display("FAIL add_result[%0d]: got %h expected %h", i, {bus.Cout, bus.Sum}, exp); else passed++;
      tick();
    end
  endtask

  task automatic test_stall();
    logic [W:0] exp, snap;
    bit ok;
    bus.done_ready = 1'b0;
    do_accept(8'hC3, 8'h5E, 1'b1, 1'b0, ok);
    checks++; if (!ok) $display("FAIL stall_accept: got timeout expected accept"); else passed++;
    for (int i = 0; i < 7; i++) begin
      checks++;
      if ({bus.start_ready, bus.busy, bus.done_valid} !== 3'b010)
        $display("FAIL stall_calc_flags[%0d]: got %b expected 010", i, {bus.start_ready, bus.busy, bus.done_valid});
      else passed++;
      bus.start_valid = 1'(i % 2);
      bus.A = 8'h11;
      bus.B = 8'h22;
      tick();
    end
    bus.start_valid = 1'b1;
    tick();
    checks++; if (bus.done_valid !== 1'b1) $display("FAIL stall_done_rise: got %b expected 1", bus.done_valid); else passed++;
    exp = (sb.size() != 0) ? sb.pop_front() : 'x;
    snap = {bus.Cout, bus.Sum};
    checks++; if (snap !== exp) $display("FAIL stall_result: got %h expected %h", snap, exp); else passed++;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({bus.done_valid, bus.start_ready, bus.Cout, bus.Sum} !== {2'b10, exp})
        $display("FAIL stall_hold[%0d]: got %b_%b_%h expected 1_0_%h", i, bus.done_valid, bus.start_ready, {bus.Cout, bus.Sum}, exp);
      else passed++;
    end
    // done handshake while start_valid is high: must not start a new op
    bus.done_ready = 1'b1;
    tick();
    bus.start_valid = 1'b0;
    checks++; if ({bus.start_ready, bus.busy, bus.done_valid} !== 3'b100) $display("FAIL stall_release: got %b expected 100", {bus.start_ready, bus.busy, bus.done_valid}); else passed++;
    checks++; if ({bus.Cout, bus.Sum} !== exp) $display("FAIL stall_post_hold: got %h expected %h", {bus.Cout, bus.Sum}, exp); else passed++;
    tick();
    checks++; if (bus.busy !== 1'b0) $display("FAIL stall_no_spurious: got %b expected 0", bus.busy); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] av[4];
    logic [W-1:0] bv[4];
    logic         cv[4];
    int unsigned  acc_t[4];
    logic [W:0]   exp;
    int na, nr, guard;
    bit rdy;
    for (int i = 0; i < 4; i++) begin
      av[i] = W'($urandom);
      bv[i] = W'($urandom);
      cv[i] = 1'($urandom);
    end
    na = 0; nr = 0; guard = 0;
    bus.done_ready = 1'b1;
    bus.A = av[0]; bus.B = bv[0]; bus.Cin = cv[0];
    bus.start_valid = 1'b1;
    while ((na < 4 || nr < 4) && guard < 100) begin
      rdy = bus.start_ready && bus.start_valid;
      tick();
      guard++;
      if (rdy) begin
        acc_t[na] = cyc;
        sb.push_back({1'b0, av[na]} + {1'b0, bv[na]} + (W+1)'(cv[na]));
        na++;
        if (na < 4) begin
          bus.A = av[na]; bus.B = bv[na]; bus.Cin = cv[na];
        end else bus.start_valid = 1'b0;
      end
      if (bus.done_valid) begin
        exp = (sb.size() != 0) ? sb.pop_front() : 'x;
        checks++; if ({bus.Cout, bus.Sum} !== exp) $display("FAIL b2b_result[%0d]: got %h expected %h", nr, {bus.Cout, bus.Sum}, exp); else passed++;
        nr++;
      end
    end
    bus.start_valid = 1'b0;
    checks++; if (guard >= 100) $display("FAIL b2b_timeout: got %0d/%0d ops expected 4/4", na, nr); else passed++;
    for (int i = 1; i < 4; i++) begin
      checks++;
      if (i < na && acc_t[i] - acc_t[i-1] !== 10) $display("FAIL b2b_interval[%0d]: got %0d expected 10", i, acc_t[i] - acc_t[i-1]);
      else if (i >= na) $display("FAIL b2b_interval[%0d]: got none expected 10", i);
      else passed++;
    end
    tick();
  endtask

  task automatic test_reset_mid();
    logic [W:0] exp;
    bit ok;
    int n;
    bus.done_ready = 1'b1;
    do_accept(8'h80, 8'h90, 1'b0, 1'b0, ok);
    wait_valid(n);
    exp = (sb.size() != 0) ? sb.pop_front() : 'x;
    checks++; if ({bus.Cout, bus.Sum} !== exp) $display("FAIL rstmid_pre_result: got %h expected %h", {bus.Cout, bus.Sum}, exp); else passed++;
    tick();
    do_accept(8'h37, 8'h11, 1'b0, 1'b0, ok);
    tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    sb.delete();
    checks++;
    if ({bus.start_ready, bus.busy, bus.done_valid, bus.Cout, bus.Sum} !== {3'b100, 9'h000})
      $display("FAIL rstmid_outputs: got %b_%b_%b_%h expected 1_0_0_000", bus.start_ready, bus.busy, bus.done_valid, {bus.Cout, bus.Sum});
    else passed++;
    rst_n = 1'b1;
    do_accept(8'h01, 8'h01, 1'b0, 1'b0, ok);
    checks++; if (!ok) $display("FAIL rstmid_accept: got timeout expected accept"); else passed++;
    wait_valid(n);
    checks++; if (n !== 8) $display("FAIL rstmid_latency: got %0d expected 8", n); else passed++;
    exp = (sb.size() != 0) ? sb.pop_front() : 'x;
    checks++; if ({bus.Cout, bus.Sum} !== 9'h002 || exp !== 9'h002) $display("FAIL rstmid_result: got %h expected 002", {bus.Cout, bus.Sum}); else passed++;
    tick();
  endtask

`ifdef RCA_SUB_EN
  task automatic test_sub();
    logic [W-1:0] av[2];
    logic [W-1:0] bv[2];
    logic [W:0]   req[2];
    logic [W:0]   exp;
    bit ok;
    int n;
    av = '{8'h10, 8'h20};
    bv = '{8'h20, 8'h10};
    req = '{9'h0F0, 9'h110};
    bus.done_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      do_accept(av[i], bv[i], 1'b0, 1'b1, ok);
      wait_valid(n);
      exp = (sb.size() != 0) ? sb.pop_front() : 'x;
      checks++; if ({bus.Cout, bus.Sum} !== req[i] || exp !== req[i]) $display("FAIL sub_result[%0d]: got %h expected %h", i, {bus.Cout, bus.Sum}, req[i]); else passed++;
      tick();
    end
    bus.sub = 1'b0;
  endtask
`endif

  initial begin
    bus.start_valid = 1'b0;
    bus.A = '0;
    bus.B = '0;
    bus.Cin = 1'b0;
    bus.done_ready = 1'b1;
`ifdef RCA_SUB_EN
    bus.sub = 1'b0;
`endif
    test_reset();
    test_add();
    test_stall();
    test_back_to_back();
    test_reset_mid();
`ifdef RCA_SUB_EN
    test_sub();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
